// File: rtl/ahb_master_interface_if.sv
// Command/response stream and AHB-Lite bus signals of the AHB initiator.
// Modports: master = initiator view, slave = command source + AHB slave view.
interface ahb_master_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic              Hwrite;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [DATA_W-1:0] Hrdata;
    logic [1:0]        Hresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  Hreadyout, Hrdata, Hresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Htrans, Haddr, Hwrite, Hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output Hreadyout, Hrdata, Hresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Htrans, Haddr, Hwrite, Hwdata
    );
endinterface

// File: rtl/ahb_master_interface.sv
// AHB-Lite initiator: command stream -> pipelined single NONSEQ transfers.
// Ports: Hclk, Hresetn (sync, active low), bus (ahb_master_interface_if.master).
module ahb_master_interface #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    ahb_master_interface_if.master bus
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    // Address slot lives in the Haddr/Hwrite registers plus a_wdata.
    logic              a_valid_q, a_valid_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic              sup_q, sup_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic cmd_ready;
    logic accept;
    logic advance;
    logic d_done;
    logic is_err;
    logic err_hold;

    assign cmd_ready = Hresetn & (~a_valid_q | (bus.Hreadyout & ~sup_q));
    assign accept    = bus.cmd_valid & cmd_ready;
    assign advance   = bus.Hreadyout & a_valid_q & ~sup_q;
    assign d_done    = bus.Hreadyout & d_valid_q;
    assign is_err    = (bus.Hresp == 2'b01);
    // First ERROR cycle with a pending address: cancel it for one cycle.
    assign err_hold  = ~bus.Hreadyout & is_err & d_valid_q
                     & a_valid_q & ~sup_q;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        sup_d       = sup_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;

        if (advance) begin
            d_valid_d = 1'b1;
            d_write_d = hwrite_q;
            if (hwrite_q) hwdata_d = a_wdata_q;
            a_valid_d = 1'b0;
            htrans_d  = IDLE;
        end else if (d_done) begin
            d_valid_d = 1'b0;
        end

        if (accept) begin
            a_valid_d = 1'b1;
            haddr_d   = bus.cmd_addr;
            hwrite_d  = bus.cmd_write;
            a_wdata_d = bus.cmd_wdata;
            htrans_d  = NONSEQ;
        end

        if (err_hold) begin
            sup_d    = 1'b1;
            htrans_d = IDLE;
        end

        // Error retires: the held address is presented again.
        if (sup_q && bus.Hreadyout) begin
            sup_d    = 1'b0;
            htrans_d = NONSEQ;
        end

        rsp_valid_d = d_done;
        rsp_rdata_d = (d_done && !d_write_q) ? bus.Hrdata : '0;
        rsp_err_d   = d_done & is_err;
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            a_valid_q   <= 1'b0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            sup_q       <= 1'b0;
            htrans_q    <= IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            sup_q       <= sup_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.Htrans    = htrans_q;
    assign bus.Haddr     = haddr_q;
    assign bus.Hwrite    = hwrite_q;
    assign bus.Hwdata    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
